// File: rtl/lcd_bus_monitor.sv
// lcd_bus_monitor: shadow model of an HD44780-style 8-bit LCD bus (2x16 DDRAM mirror, mode flags, violation log).
// Latency: strobe effects land on the 3rd clk edge after lcd_e is first sampled low; rd_char follows rd_addr by 1 cycle.
// Backpressure: none; the bus cannot be stalled, so bad strobes are dropped and counted in err_count/timing_err.
module lcd_bus_monitor #(
  parameter int E_MIN_HIGH = 12,
  parameter int BUSY_CMD   = 2000,
  parameter int BUSY_CLR   = 82000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       lcd_rs,
  input  logic       lcd_rw,
  input  logic       lcd_e,
  input  logic [7:0] lcd_data,
  input  logic [4:0] rd_addr,
  output logic [7:0] rd_char,
  output logic [6:0] cur_addr,
  output logic       disp_on,
  output logic       cursor_on,
  output logic       blink_on,
  output logic       two_line,
  output logic       eight_bit,
  output logic       init_done,
  output logic       busy,
  output logic       cmd_strobe,
  output logic       wr_strobe,
  output logic       frame_done,
  output logic       timing_err,
  output logic [7:0] err_count
);

  localparam int BW = $clog2(((BUSY_CLR > BUSY_CMD) ? BUSY_CLR : BUSY_CMD) + 1);
  localparam logic [BW-1:0] BUSY_CMD_V = BW'(BUSY_CMD);
  localparam logic [BW-1:0] BUSY_CLR_V = BW'(BUSY_CLR);
  localparam logic [15:0]   E_MIN_V    = 16'(E_MIN_HIGH);

  typedef enum logic [1:0] {ST_UNINIT, ST_SYNC, ST_READY} init_state_t;

  // Address counter step with the two-line DDRAM wrap points; unmapped ranges step modulo 128.
  function automatic logic [6:0] step_addr(input logic [6:0] a, input logic up);
    logic [6:0] r;
    if (up) begin
      if (a == 7'h27)      r = 7'h40;
      else if (a == 7'h67) r = 7'h00;
      else                 r = a + 7'd1;
    end else begin
      if (a == 7'h00)      r = 7'h67;
      else if (a == 7'h40) r = 7'h27;
      else                 r = a - 7'd1;
    end
    return r;
  endfunction

  logic [1:0]    e_sync, rs_sync, rw_sync;
  logic [7:0]    dat_meta, dat_sync;
  logic          e_s, e_d, fall;
  logic [15:0]   e_width;
  logic          last_rs, last_rw;
  logic [7:0]    last_dat;
  logic          p_vld, p_rs, p_rw;
  logic [7:0]    p_dat;
  logic [15:0]   p_width;
  logic          ready, is_fs, bad, viol, acc, acc_cmd, acc_wr, cmd_rdy, clr_home, enter_ready;
  logic          in_shadow;
  init_state_t   state, state_nxt;
  logic [1:0]    sync_cnt, sync_cnt_nxt;
  logic [BW-1:0] busy_cnt;
  logic          fill_vld;
  logic [4:0]    fill_idx;
  logic          inc_mode, cg_mode;
  logic [7:0]    shadow [32];

  assign e_s  = e_sync[1];
  assign fall = e_d & ~e_s;

  // Two-flop synchronizers on every bus input; the LCD bus is asynchronous to clk.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      e_sync   <= '0;
      rs_sync  <= '0;
      rw_sync  <= '0;
      dat_meta <= '0;
      dat_sync <= '0;
    end else begin
      e_sync   <= {e_sync[0], lcd_e};
      rs_sync  <= {rs_sync[0], lcd_rs};
      rw_sync  <= {rw_sync[0], lcd_rw};
      dat_meta <= lcd_data;
      dat_sync <= dat_meta;
    end
  end

  // Measure E-high width, hold the last high-cycle sample, and register it as a pending strobe on the fall.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      e_d      <= 1'b0;
      e_width  <= '0;
      last_rs  <= 1'b0;
      last_rw  <= 1'b0;
      last_dat <= '0;
      p_vld    <= 1'b0;
      p_rs     <= 1'b0;
      p_rw     <= 1'b0;
      p_dat    <= '0;
      p_width  <= '0;
    end else begin
      e_d   <= e_s;
      p_vld <= fall;
      if (e_s) begin
        e_width  <= e_d ? ((e_width == 16'hFFFF) ? e_width : e_width + 16'd1) : 16'd1;
        last_rs  <= rs_sync[1];
        last_rw  <= rw_sync[1];
        last_dat <= dat_sync;
      end
      if (fall) begin
        p_rs    <= last_rs;
        p_rw    <= last_rw;
        p_dat   <= last_dat;
        p_width <= e_width;
      end
    end
  end

  assign ready     = (state == ST_READY);
  assign init_done = ready;
  assign busy      = (busy_cnt != '0) | fill_vld;
  assign is_fs     = ~p_rs & (p_dat[7:5] == 3'b001);
  assign bad       = (p_width < E_MIN_V) | p_rw | (busy & ready) | (~ready & ~is_fs);
  assign viol      = p_vld & bad;
  assign acc       = p_vld & ~bad;
  assign acc_cmd   = acc & ~p_rs;
  assign acc_wr    = acc & p_rs;
  assign cmd_rdy   = acc_cmd & ready;
  assign clr_home  = cmd_rdy & (p_dat[7:2] == 6'b0) & (p_dat[1:0] != 2'b00);
  assign in_shadow = (cur_addr[6:4] == 3'b000) | (cur_addr[6:4] == 3'b100);
  assign enter_ready = acc_cmd & (state == ST_SYNC) & (state_nxt == ST_READY);

  // Init recogniser state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_UNINIT;
      sync_cnt <= '0;
    end else begin
      state    <= state_nxt;
      sync_cnt <= sync_cnt_nxt;
    end
  end

  // Init recogniser: count 0x3X function sets, then the next DL=1 function set completes init.
  always_comb begin
    state_nxt    = state;
    sync_cnt_nxt = sync_cnt;
    if (acc_cmd) begin
      case (state)
        ST_UNINIT: begin
          if (p_dat[7:4] == 4'h3) begin
            state_nxt    = ST_SYNC;
            sync_cnt_nxt = 2'd1;
          end else begin
            sync_cnt_nxt = 2'd0;
          end
        end
        ST_SYNC: begin
          if ((sync_cnt == 2'd3) && is_fs && p_dat[4]) begin
            state_nxt = ST_READY;
          end else if (p_dat[7:4] == 4'h3) begin
            sync_cnt_nxt = sync_cnt + 2'd1;
          end else begin
            state_nxt    = ST_UNINIT;
            sync_cnt_nxt = 2'd0;
          end
        end
        default: ;
      endcase
    end
  end

  // Apply accepted strobes: command decode, shadow writes, clear fill, busy window and violation log.
  // Display shift only changes what the glass shows, not DDRAM, so the entry-mode S bit is not kept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) shadow[i] <= 8'h20;
      rd_char    <= 8'h20;
      cur_addr   <= '0;
      inc_mode   <= 1'b1;
      cg_mode    <= 1'b0;
      disp_on    <= 1'b0;
      cursor_on  <= 1'b0;
      blink_on   <= 1'b0;
      two_line   <= 1'b0;
      eight_bit  <= 1'b0;
      busy_cnt   <= '0;
      fill_vld   <= 1'b0;
      fill_idx   <= '0;
      cmd_strobe <= 1'b0;
      wr_strobe  <= 1'b0;
      frame_done <= 1'b0;
      timing_err <= 1'b0;
      err_count  <= '0;
    end else begin
      rd_char    <= shadow[rd_addr];
      cmd_strobe <= acc_cmd;
      wr_strobe  <= acc_wr;
      frame_done <= 1'b0;

      if (viol) begin
        timing_err <= 1'b1;
        if (err_count != 8'hFF) err_count <= err_count + 8'd1;
      end

      if (acc)                  busy_cnt <= clr_home ? BUSY_CLR_V : BUSY_CMD_V;
      else if (busy_cnt != '0) busy_cnt <= busy_cnt - BW'(1);

      if (fill_vld) begin
        shadow[fill_idx] <= 8'h20;
        fill_idx         <= fill_idx + 5'd1;
        if (fill_idx == 5'd31) fill_vld <= 1'b0;
      end

      if (enter_ready) begin
        two_line  <= p_dat[3];
        eight_bit <= p_dat[4];
      end

      if (cmd_rdy) begin
        if (p_dat[7]) begin
          cur_addr <= p_dat[6:0];
          cg_mode  <= 1'b0;
        end else if (p_dat[6]) begin
          cg_mode <= 1'b1;
        end else if (p_dat[5]) begin
          two_line  <= p_dat[3];
          eight_bit <= p_dat[4];
        end else if (p_dat[4]) begin
          if (!p_dat[3]) cur_addr <= step_addr(cur_addr, p_dat[2]);
        end else if (p_dat[3]) begin
          disp_on   <= p_dat[2];
          cursor_on <= p_dat[1];
          blink_on  <= p_dat[0];
        end else if (p_dat[2]) begin
          inc_mode <= p_dat[1];
        end else if (p_dat[1]) begin
          cur_addr <= '0;
          cg_mode  <= 1'b0;
        end else if (p_dat[0]) begin
          cur_addr <= '0;
          cg_mode  <= 1'b0;
          inc_mode <= 1'b1;
          fill_vld <= 1'b1;
          fill_idx <= '0;
        end
      end

      if (acc_wr) begin
        if (!cg_mode && in_shadow) begin
          shadow[{cur_addr[6], cur_addr[3:0]}] <= p_dat;
          frame_done <= (cur_addr == 7'h4F);
        end
        cur_addr <= step_addr(cur_addr, inc_mode);
      end
    end
  end

endmodule

// File: tb/tb_lcd_bus_monitor.sv
// Bench for lcd_bus_monitor: drives HD44780-style bus cycles and scores strobes, flags and shadow contents.
// Busy windows are scaled down through parameters so the run stays short.
module tb_lcd_bus_monitor;
  localparam int EMIN = 12;
  localparam int BCMD = 100;
  localparam int BCLR = 2000;
  localparam int EW   = 16;
  localparam int GAP  = 130;
  localparam int GAPC = 2100;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       lcd_rs = 1'b0, lcd_rw = 1'b0, lcd_e = 1'b0;
  logic [7:0] lcd_data = 8'h00;
  logic [4:0] rd_addr = 5'd0;
  logic [7:0] rd_char, err_count;
  logic [6:0] cur_addr;
  logic       disp_on, cursor_on, blink_on, two_line, eight_bit, init_done, busy;
  logic       cmd_strobe, wr_strobe, frame_done, timing_err;

  int n_chk = 0;
  int n_fail = 0;
  int frame_cnt = 0;
  logic [1:0] exp_q [$];
  logic [7:0] exp_buf [32];

  lcd_bus_monitor #(.E_MIN_HIGH(EMIN), .BUSY_CMD(BCMD), .BUSY_CLR(BCLR)) dut (
    .clk(clk), .rst(rst), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_e(lcd_e), .lcd_data(lcd_data),
    .rd_addr(rd_addr), .rd_char(rd_char), .cur_addr(cur_addr), .disp_on(disp_on), .cursor_on(cursor_on),
    .blink_on(blink_on), .two_line(two_line), .eight_bit(eight_bit), .init_done(init_done), .busy(busy),
    .cmd_strobe(cmd_strobe), .wr_strobe(wr_strobe), .frame_done(frame_done), .timing_err(timing_err),
    .err_count(err_count)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (frame_done) frame_cnt <= frame_cnt + 1;

  // One bus cycle; expected strobe kind is queued up front and popped when the DUT pulses.
  task automatic send(input logic rs, input logic rw, input logic [7:0] d, input int width,
                      input bit exp_acc, input int gap, input string nm);
    bit seen;
    logic [1:0] got, want;
    seen = 1'b0;
    if (exp_acc) exp_q.push_back(rs ? 2'b01 : 2'b10);
    @(negedge clk);
    lcd_rs = rs; lcd_rw = rw; lcd_data = d; lcd_e = 1'b1;
    repeat (width) @(negedge clk);
    lcd_e = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (cmd_strobe || wr_strobe) begin
        got = {cmd_strobe, wr_strobe};
        seen = 1'b1;
        n_chk++;
        if (exp_q.size() == 0) begin
          n_fail++; $display("FAIL %s strobe: got %b, required no strobe", nm, got);
        end else begin
          want = exp_q.pop_front();
          if (got !== want) begin n_fail++; $display("FAIL %s strobe kind: got %b, required %b", nm, got, want); end
        end
      end
    end
    n_chk++;
    if (seen != exp_acc) begin
      n_fail++; $display("FAIL %s accepted: got %0d, required %0d", nm, seen, exp_acc);
      exp_q.delete();
    end
    repeat (gap) @(negedge clk);
  endtask

  task automatic read_cell(input int a, output logic [7:0] v);
    @(negedge clk);
    rd_addr = a[4:0];
    @(negedge clk);
    v = rd_char;
  endtask

  task automatic test_reset;
    logic [7:0] v;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_chk++; if (init_done !== 1'b0) begin n_fail++; $display("FAIL rst init_done: got %b, required 0", init_done); end
    n_chk++; if (cur_addr !== 7'h00) begin n_fail++; $display("FAIL rst cur_addr: got %h, required 00", cur_addr); end
    n_chk++; if ({busy, timing_err, cmd_strobe, wr_strobe, frame_done} !== 5'b0) begin
      n_fail++; $display("FAIL rst status: got %b, required 00000", {busy, timing_err, cmd_strobe, wr_strobe, frame_done}); end
    n_chk++; if (err_count !== 8'h00) begin n_fail++; $display("FAIL rst err_count: got %0d, required 0", err_count); end
    n_chk++; if ({disp_on, cursor_on, blink_on, two_line, eight_bit} !== 5'b0) begin
      n_fail++; $display("FAIL rst flags: got %b, required 00000", {disp_on, cursor_on, blink_on, two_line, eight_bit}); end
    n_chk++; if (rd_char !== 8'h20) begin n_fail++; $display("FAIL rst rd_char: got %h, required 20", rd_char); end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 32; i++) exp_buf[i] = 8'h20;
    read_cell(17, v);
    n_chk++; if (v !== 8'h20) begin n_fail++; $display("FAIL rst cell17: got %h, required 20", v); end
    read_cell(31, v);
    n_chk++; if (v !== 8'h20) begin n_fail++; $display("FAIL rst cell31: got %h, required 20", v); end
  endtask

  task automatic test_init;
    logic [7:0] seq [8];
    seq = '{8'h30, 8'h30, 8'h30, 8'h38, 8'h08, 8'h01, 8'h06, 8'h0C};
    for (int i = 0; i < 8; i++) send(1'b0, 1'b0, seq[i], 300, 1'b1, (seq[i] == 8'h01) ? GAPC : GAP, "init");
    n_chk++; if (init_done !== 1'b1) begin n_fail++; $display("FAIL init init_done: got %b, required 1", init_done); end
    n_chk++; if ({two_line, eight_bit} !== 2'b11) begin n_fail++; $display("FAIL init N/DL: got %b, required 11", {two_line, eight_bit}); end
    n_chk++; if ({disp_on, cursor_on, blink_on} !== 3'b100) begin
      n_fail++; $display("FAIL init D/C/B: got %b, required 100", {disp_on, cursor_on, blink_on}); end
    n_chk++; if (err_count !== 8'h00) begin n_fail++; $display("FAIL init err_count: got %0d, required 0", err_count); end
    n_chk++; if (cur_addr !== 7'h00) begin n_fail++; $display("FAIL init cur_addr: got %h, required 00", cur_addr); end
  endtask

  task automatic test_frame;
    string l1, l2;
    int f0;
    logic [7:0] v;
    l1 = "ODO: 12345 km   ";
    l2 = " FUEL:  87 %    ";
    f0 = frame_cnt;
    send(1'b0, 1'b0, 8'h80, EW, 1'b1, GAP, "set80");
    for (int i = 0; i < 16; i++) begin send(1'b1, 1'b0, l1[i], EW, 1'b1, GAP, "line1"); exp_buf[i] = l1[i]; end
    n_chk++; if (frame_cnt != f0) begin n_fail++; $display("FAIL frame early: got %0d pulses, required 0", frame_cnt - f0); end
    n_chk++; if (cur_addr !== 7'h10) begin n_fail++; $display("FAIL line1 cur_addr: got %h, required 10", cur_addr); end
    send(1'b0, 1'b0, 8'hC0, EW, 1'b1, GAP, "setC0");
    for (int i = 0; i < 16; i++) begin send(1'b1, 1'b0, l2[i], EW, 1'b1, GAP, "line2"); exp_buf[16 + i] = l2[i]; end
    n_chk++; if (frame_cnt - f0 != 1) begin n_fail++; $display("FAIL frame_done: got %0d pulses, required 1", frame_cnt - f0); end
    n_chk++; if (cur_addr !== 7'h50) begin n_fail++; $display("FAIL frame cur_addr: got %h, required 50", cur_addr); end
    read_cell(5, v);
    n_chk++; if (v !== 8'h31) begin n_fail++; $display("FAIL frame cell5: got %h, required 31", v); end
    read_cell(24, v);
    n_chk++; if (v !== 8'h38) begin n_fail++; $display("FAIL frame cell24: got %h, required 38", v); end
    read_cell(20, v);
    n_chk++; if (v !== 8'h4C) begin n_fail++; $display("FAIL frame cell20: got %h, required 4c", v); end
    for (int i = 0; i < 32; i++) begin
      read_cell(i, v);
      n_chk++; if (v !== exp_buf[i]) begin n_fail++; $display("FAIL frame buf[%0d]: got %h, required %h", i, v, exp_buf[i]); end
    end
  endtask

  task automatic test_short_e;
    logic [7:0] v;
    send(1'b0, 1'b0, 8'h80, EW, 1'b1, GAP, "set80b");
    send(1'b1, 1'b0, 8'h58, 5, 1'b0, GAP, "short_e");
    n_chk++; if (timing_err !== 1'b1) begin n_fail++; $display("FAIL short_e timing_err: got %b, required 1", timing_err); end
    n_chk++; if (err_count !== 8'd1) begin n_fail++; $display("FAIL short_e err_count: got %0d, required 1", err_count); end
    n_chk++; if (cur_addr !== 7'h00) begin n_fail++; $display("FAIL short_e cur_addr: got %h, required 00", cur_addr); end
    read_cell(0, v);
    n_chk++; if (v !== exp_buf[0]) begin n_fail++; $display("FAIL short_e cell0: got %h, required %h", v, exp_buf[0]); end
  endtask

  task automatic test_busy;
    logic [7:0] v;
    send(1'b0, 1'b0, 8'h01, EW, 1'b1, 0, "clear");
    n_chk++; if (busy !== 1'b1) begin n_fail++; $display("FAIL clear busy: got %b, required 1", busy); end
    repeat (400) @(negedge clk);
    send(1'b0, 1'b0, 8'h80, EW, 1'b0, GAPC, "busy_drop");
    n_chk++; if (err_count !== 8'd2) begin n_fail++; $display("FAIL busy_drop err_count: got %0d, required 2", err_count); end
    for (int i = 0; i < 32; i++) exp_buf[i] = 8'h20;
    read_cell(0, v);
    n_chk++; if (v !== 8'h20) begin n_fail++; $display("FAIL clear cell0: got %h, required 20", v); end
    read_cell(24, v);
    n_chk++; if (v !== 8'h20) begin n_fail++; $display("FAIL clear cell24: got %h, required 20", v); end
    send(1'b0, 1'b0, 8'h01, EW, 1'b1, GAPC, "clear2");
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL clear2 busy expiry: got %b, required 0", busy); end
    send(1'b0, 1'b0, 8'h80, EW, 1'b1, GAP, "busy_ok");
    n_chk++; if (err_count !== 8'd2) begin n_fail++; $display("FAIL busy_ok err_count: got %0d, required 2", err_count); end
  endtask

  task automatic test_decrement;
    logic [7:0] v;
    send(1'b0, 1'b0, 8'h04, EW, 1'b1, GAP, "entry_dec");
    send(1'b0, 1'b0, 8'hC0, EW, 1'b1, GAP, "setC0b");
    send(1'b1, 1'b0, 8'h41, EW, 1'b1, GAP, "wr_A");
    send(1'b1, 1'b0, 8'h42, EW, 1'b1, GAP, "wr_B");
    exp_buf[16] = 8'h41;
    n_chk++; if (cur_addr !== 7'h26) begin n_fail++; $display("FAIL dec cur_addr: got %h, required 26", cur_addr); end
    read_cell(16, v);
    n_chk++; if (v !== 8'h41) begin n_fail++; $display("FAIL dec cell16: got %h, required 41", v); end
    read_cell(15, v);
    n_chk++; if (v !== 8'h20) begin n_fail++; $display("FAIL dec cell15: got %h, required 20", v); end
    read_cell(31, v);
    n_chk++; if (v !== 8'h20) begin n_fail++; $display("FAIL dec cell31: got %h, required 20", v); end
    send(1'b0, 1'b0, 8'h06, EW, 1'b1, GAP, "entry_inc");
  endtask

  task automatic test_rw_cg;
    logic [7:0] v;
    send(1'b0, 1'b1, 8'h80, EW, 1'b0, GAP, "rw_read");
    n_chk++; if (err_count !== 8'd3) begin n_fail++; $display("FAIL rw err_count: got %0d, required 3", err_count); end
    n_chk++; if (cur_addr !== 7'h26) begin n_fail++; $display("FAIL rw cur_addr: got %h, required 26", cur_addr); end
    send(1'b0, 1'b0, 8'h80, EW, 1'b1, GAP, "set80c");
    send(1'b0, 1'b0, 8'h45, EW, 1'b1, GAP, "set_cg");
    send(1'b1, 1'b0, 8'h55, EW, 1'b1, GAP, "cg_write");
    n_chk++; if (cur_addr !== 7'h01) begin n_fail++; $display("FAIL cg cur_addr: got %h, required 01", cur_addr); end
    n_chk++; if (err_count !== 8'd3) begin n_fail++; $display("FAIL cg err_count: got %0d, required 3", err_count); end
    read_cell(0, v);
    n_chk++; if (v !== exp_buf[0]) begin n_fail++; $display("FAIL cg cell0: got %h, required %h", v, exp_buf[0]); end
  endtask

  task automatic test_reset_mid_fill;
    logic [7:0] v;
    send(1'b0, 1'b0, 8'hCE, EW, 1'b1, GAP, "setCE");
    send(1'b1, 1'b0, 8'h48, EW, 1'b1, GAP, "wr_H");
    send(1'b1, 1'b0, 8'h49, EW, 1'b1, GAP, "wr_I");
    read_cell(30, v);
    n_chk++; if (v !== 8'h48) begin n_fail++; $display("FAIL pre-fill cell30: got %h, required 48", v); end
    send(1'b0, 1'b0, 8'h01, EW, 1'b1, 0, "clear_fill");
    n_chk++; if (busy !== 1'b1) begin n_fail++; $display("FAIL fill busy: got %b, required 1", busy); end
    rst = 1'b1;
    #1;
    n_chk++; if ({init_done, busy, timing_err} !== 3'b000) begin
      n_fail++; $display("FAIL midfill rst status: got %b, required 000", {init_done, busy, timing_err}); end
    n_chk++; if (err_count !== 8'h00) begin n_fail++; $display("FAIL midfill rst err_count: got %0d, required 0", err_count); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    n_chk++; if ({disp_on, two_line, eight_bit, cur_addr} !== 10'b0) begin
      n_fail++; $display("FAIL midfill flags/addr: got %b, required 0", {disp_on, two_line, eight_bit, cur_addr}); end
    read_cell(30, v);
    n_chk++; if (v !== 8'h20) begin n_fail++; $display("FAIL midfill cell30: got %h, required 20", v); end
    read_cell(31, v);
    n_chk++; if (v !== 8'h20) begin n_fail++; $display("FAIL midfill cell31: got %h, required 20", v); end
    read_cell(16, v);
    n_chk++; if (v !== 8'h20) begin n_fail++; $display("FAIL midfill cell16: got %h, required 20", v); end
  endtask

  initial begin
    test_reset;
    test_init;
    test_frame;
    test_short_e;
    test_busy;
    test_decrement;
    test_rw_cg;
    test_reset_mid_fill;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
